// File: rtl/mips_wb_pkg.sv
// Shared types for the register-file write-port arbiter: write entry layout,
// arbiter states and grant sources.
package mips_wb_pkg;

    localparam int REG_AW    = 5;
    localparam int WB_DATA_W = 32;

    // Entry layout at the default 32-bit datapath width.
    typedef struct packed {
        logic [REG_AW-1:0]    addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        ARB   = 1'b0,
        FORCE = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_MD   = 2'd2
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding mult/div results until they win the write port.
// DEPTH must be a power of two so the pointers wrap for free.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between MEM/WB and the mult/div unit.
// Optional WBARB_BYPASS_EN lets an idle-cycle mult/div result skip the FIFO.
module wb_port_arbiter
    import mips_wb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic              MemToReg,
    input  logic [W-1:0]      MemRes,
    input  logic [W-1:0]      AluRes,
    input  logic [REG_AW-1:0] WriteRegister,
    input  logic              md_valid,
    input  logic [W-1:0]      md_data,
    input  logic [REG_AW-1:0] md_reg,
    output logic              md_ready,
    output logic              md_busy,
    output logic              stall_pipe,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [W-1:0]      rf_wdata
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(MAX_WAIT+1);
    localparam logic [SW-1:0] STARVE_TC = SW'(MAX_WAIT-1);

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [W-1:0]      data;
    } md_entry_t;

    md_entry_t   fifo_din;
    md_entry_t   fifo_dout;
    md_entry_t   md_sel;
    logic [CW-1:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;

    arb_state_t  state;
    arb_state_t  state_next;
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_next;
    wb_src_t     src;

    logic        pipe_req;
    logic        fifo_req;
    logic        push;
    logic        pop;
    logic        bypass;
    logic [W-1:0] pipe_data;

    logic              we_next;
    logic [REG_AW-1:0] waddr_next;
    logic [W-1:0]      wdata_next;

    assign pipe_req  = RegWrite && (WriteRegister != '0);
    assign pipe_data = MemToReg ? MemRes : AluRes;
    assign fifo_req  = !fifo_empty;
    assign md_ready  = (fifo_count < CW'(DEPTH));
    assign md_busy   = !fifo_empty;
    assign push      = md_valid && !fifo_full && !bypass;
    assign fifo_din  = '{addr: md_reg, data: md_data};

    wb_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(md_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        src         = SRC_NONE;
        pop         = 1'b0;
        bypass      = 1'b0;
        state_next  = state;
        starve_next = starve;
        case (state)
            ARB: begin
                if (pipe_req) begin
                    src = SRC_PIPE;
                    if (!fifo_req) begin
                        starve_next = '0;
                    end else if (starve == STARVE_TC) begin
                        state_next  = FORCE;
                        starve_next = '0;
                    end else begin
                        starve_next = starve + SW'(1);
                    end
                end else if (fifo_req) begin
                    src         = SRC_MD;
                    pop         = 1'b1;
                    starve_next = '0;
                end else begin
                    starve_next = '0;
`ifdef WBARB_BYPASS_EN
                    if (md_valid) begin
                        src    = SRC_MD;
                        bypass = 1'b1;
                    end
`endif
                end
            end
            FORCE: begin
                // MEM/WB is frozen by stall_pipe, so its request is ignored here.
                state_next  = ARB;
                starve_next = '0;
                if (fifo_req) begin
                    src = SRC_MD;
                    pop = 1'b1;
                end
            end
            default: begin
                state_next  = ARB;
                starve_next = '0;
            end
        endcase
    end

    always_comb begin
        md_sel     = bypass ? fifo_din : fifo_dout;
        we_next    = 1'b0;
        waddr_next = rf_waddr;
        wdata_next = rf_wdata;
        case (src)
            SRC_PIPE: begin
                we_next    = 1'b1;
                waddr_next = WriteRegister;
                wdata_next = pipe_data;
            end
            SRC_MD: begin
                // Results aimed at r0 are consumed here without touching the port.
                if (md_sel.addr != '0) begin
                    we_next    = 1'b1;
                    waddr_next = md_sel.addr;
                    wdata_next = md_sel.data;
                end
            end
            default: begin
                we_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            starve     <= '0;
            stall_pipe <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            state      <= state_next;
            starve     <= starve_next;
            stall_pipe <= (state_next == FORCE);
            rf_we      <= we_next;
            rf_waddr   <= waddr_next;
            rf_wdata   <= wdata_next;
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between the MEM/WB pipeline stage and a long-latency mult/div unit.
- Pipeline results have priority. Mult/div results wait in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall so queued mult/div results drain.
- Sits between the MEM/WB pipeline register, the mult/div unit and the register file.

Parameters:
- DEPTH, 2, mult/div holding FIFO entries; power of two, >=2.
- MAX_WAIT, 4, consecutive cycles the FIFO head may lose to the pipeline before a forced grant; >=1.
- W, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- RegWrite  in  1  MEM/WB write enable.
- MemToReg  in  1  1 selects MemRes, 0 selects AluRes.
- MemRes  in  W  memory read result.
- AluRes  in  W  ALU result.
- WriteRegister  in  5  MEM/WB destination register.
- md_valid  in  1  mult/div result offered.
- md_data  in  W  mult/div result.
- md_reg  in  5  mult/div destination register.
- md_ready  out  1  FIFO can accept (count < DEPTH); combinational from count.
- md_busy  out  1  FIFO non-empty; issue logic uses it to hold dependent instructions.
- stall_pipe  out  1  registered; pipeline must hold MEM/WB contents this cycle.
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  5  registered write address.
- rf_wdata  out  W  registered write data.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, stall_pipe=0, FIFO empty (md_ready=1, md_busy=0), starve count=0, state ARB.
- Reset mid-operation discards FIFO contents; no write issues in the reset cycle or the cycle after.
- Pipeline request: pipe_req = RegWrite && WriteRegister!=0.
- Pipeline write data: MemToReg ? MemRes : AluRes.
- FIFO request: fifo_req = FIFO non-empty.
- Push: md_valid && md_ready pushes {md_reg, md_data} at the clock edge.
- Dropped pushes: entries with md_reg==0 are accepted, then dropped silently. They are popped on their first grant opportunity without asserting rf_we.
- Grant timing: grant is combinational in cycle N. rf_* reflect the winner at N+1 (1-cycle latency). With no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- State ARB:
  - pipe_req=1: grant pipeline. If fifo_req=1, starve count increments.
  - pipe_req=0 and fifo_req=1: grant FIFO head, pop, starve count clears.
  - FIFO empty: starve count clears.
  - Transition: pipe_req && fifo_req && count==MAX_WAIT-1 -> FORCE at the next edge, count clears.
- State FORCE (exactly one cycle):
  - stall_pipe=1 and the FIFO head is granted and popped.
  - Pipeline inputs are ignored; they are held by the stalled MEM/WB register and re-presented next cycle.
  - Returns to ARB.
- Simultaneous push and pop: both take effect, count unchanged.
- Push when full: impossible, md_ready=0.
- Pop and push in the same cycle at count==DEPTH: md_ready is still 0 that cycle; no lookahead.
- Ordering: FIFO entries are written oldest-first. Write-after-write ordering against pipeline writes is the issue logic's job via md_busy; the arbiter does not compare addresses.

Optional Feature:
- Macro: WBARB_BYPASS_EN.
- Defined: when md_valid=1, FIFO empty, pipe_req=0 and state ARB, the offered result is granted directly without entering the FIFO. md_valid at N -> rf_we at N+1.
- Undefined: every mult/div result passes through the FIFO. md_valid at N -> earliest rf_we at N+2.

Decomposition:
- Package mips_wb_pkg:
  - REG_AW=5.
  - Typedef wb_entry_t {addr, data}.
  - Enum arb_state_t {ARB, FORCE}.
  - Enum wb_src_t {SRC_NONE, SRC_PIPE, SRC_MD}.
- Sub-module wb_fifo: synchronous FIFO parameterised by DEPTH. Ports: push, pop, din, dout, count, full, empty; synchronous reset.

Test Plan:
- Reset: rst=1 for 2 cycles with RegWrite=1, WriteRegister=8 -> rf_we=0 throughout and one cycle after release; md_ready=1, stall_pipe=0.
- Pipeline write: RegWrite=1, MemToReg=1, MemRes=0xDEADBEEF, WriteRegister=9 at N -> at N+1 rf_we=1, rf_waddr=9, rf_wdata=0xDEADBEEF. WriteRegister=0 -> rf_we=0.
- Mult/div idle path, bypass undefined: md_valid=1, md_reg=4, md_data=0x12345678 at N, pipeline idle -> rf_we=1, rf_waddr=4 at N+2. With WBARB_BYPASS_EN -> at N+1.
- Starvation, MAX_WAIT=4: one queued entry (reg 5) with pipe_req=1 every cycle -> 4 pipeline writes, then stall_pipe=1 for one cycle and rf_waddr=5 the cycle after the forced grant. Held pipeline write appears next.
- FIFO full: 3 md_valid pulses while pipe_req=1 continuously, DEPTH=2 -> md_ready=0 after second push, third offer not accepted; md_ready returns to 1 the cycle after the first pop.
- Reset mid-queue: two entries queued, rst pulse -> md_busy=0 next cycle, neither entry is ever written.
